// File: rtl/mpeg2_stream_feeder_pkg.sv
// Shared types and constants for the MPEG-2 stimulus stream feeder.
package mpeg2_stream_feeder_pkg;

   typedef enum logic [2:0] {
      PFX0,
      PFX1,
      PFX2,
      CODE,
      PAYLOAD,
      DONE
   } state_t;

   localparam int unsigned LFSR_W = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam logic [BYTE_W-1:0] EMU_SUB   = 8'h80;

   // Start codes in emission order; entry 0 is used first after reset.
   localparam logic [3:0][BYTE_W-1:0] START_CODES = {8'h01, 8'h00, 8'hB8, 8'hB3};

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/stream_lfsr16.sv
// 16-bit right-shifting Galois LFSR; a zero seed is replaced by 0001.
module stream_lfsr16
   import mpeg2_stream_feeder_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output logic [15:0] value
);

   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge clk) begin
      if (reset)     value <= INIT;
      else if (step) value <= lfsr_next(value);
   end

endmodule

// File: rtl/mpeg2_stream_feeder.sv
// Start-code-framed pseudo-random byte source feeding the decoder input,
// stalled by decoder busy and optionally stopping after NUM_UNITS units.
module mpeg2_stream_feeder
   import mpeg2_stream_feeder_pkg::*;
#(
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned PAYLOAD_LEN = 64,
   parameter int unsigned NUM_UNITS   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        busy,
   output logic [7:0]  stream_data,
   output logic        stream_valid,
   output logic [15:0] unit_count,
   output logic [31:0] byte_count,
   output logic        done
);

   state_t      state, state_n;
   logic [15:0] lfsr_val;
   logic [15:0] pay_cnt;
   logic [1:0]  code_idx;
   logic [7:0]  prev_byte;
   logic [7:0]  cand;
   logic [7:0]  out_byte;
   logic [15:0] unit_inc;
   logic        emit;
   logic        pay_last;
   logic        unit_end;

   assign emit     = enable && !busy && (state != DONE);
   assign cand     = 8'(lfsr_next(lfsr_val));
   assign pay_last = (pay_cnt == 16'(PAYLOAD_LEN - 1));
   assign unit_inc = unit_count + 16'd1;

   stream_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (emit && (state == PAYLOAD)),
      .value (lfsr_val)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= PFX0;
      else       state <= state_n;
   end

   // Next state, byte to emit this cycle and end-of-unit detection.
   always_comb begin
      state_n  = state;
      out_byte = 8'h00;
      unit_end = 1'b0;
      case (state)
         PFX0: if (emit) state_n = PFX1;
         PFX1: if (emit) state_n = PFX2;
         PFX2: begin
            out_byte = 8'h01;
            if (emit) state_n = CODE;
         end
         CODE: begin
            out_byte = START_CODES[code_idx];
            if (emit) state_n = PAYLOAD;
         end
         PAYLOAD: begin
            out_byte = (prev_byte == 8'h00 && cand == 8'h00) ? EMU_SUB : cand;
            if (emit && pay_last) begin
               unit_end = 1'b1;
               state_n  = (NUM_UNITS != 0 && unit_inc == 16'(NUM_UNITS)) ? DONE : PFX0;
            end
         end
         DONE:    state_n = DONE;
         default: state_n = PFX0;
      endcase
   end

   // Output registers, counters and emulation-guard history.
   always_ff @(posedge clk) begin
      if (reset) begin
         stream_data  <= 8'h00;
         stream_valid <= 1'b0;
         unit_count   <= 16'd0;
         byte_count   <= 32'd0;
         done         <= 1'b0;
         prev_byte    <= 8'hFF;
         pay_cnt      <= 16'd0;
         code_idx     <= 2'd0;
      end else if (emit) begin
         stream_data  <= out_byte;
         stream_valid <= 1'b1;
         byte_count   <= byte_count + 32'd1;
         prev_byte    <= out_byte;
         if (state == PAYLOAD) pay_cnt <= pay_last ? 16'd0 : pay_cnt + 16'd1;
         if (unit_end) begin
            unit_count <= unit_inc;
            code_idx   <= code_idx + 2'd1;
            if (state_n == DONE) done <= 1'b1;
         end
      end else begin
         stream_valid <= 1'b0;
      end
   end

endmodule
